// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - single-outstanding instruction fetch sequencer between imem and decode
// Define FETCH_STATS_EN to add the stat_fetched / stat_stall counters.
module fetch_controller #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter int unsigned          PC_STEP  = 4,
    parameter int unsigned          MAX_WAIT = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_W-1:0]   imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [DATA_W-1:0]   imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [DATA_W-1:0]   inst_data,
    output logic [ADDR_W-1:0]   inst_pc,
`ifdef FETCH_STATS_EN
    output logic                fetch_error,
    output logic [31:0]         stat_fetched,
    output logic [31:0]         stat_stall
`else
    output logic                fetch_error
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  inst_data_q, inst_data_d;
    logic [ADDR_W-1:0]  inst_pc_q, inst_pc_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            inst_data_q <= '0;
            inst_pc_q   <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Redirect only retargets the PC; each state decides how the in-flight request is retired.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end

        case (state_q)
            S_IDLE: begin
                if (!redirect_valid && enable && !err_q) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (imem_req_ready) begin
                    cnt_d   = '0;
                    state_d = redirect_valid ? S_DRAIN : S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    cnt_d   = '0;
                    state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (imem_rsp_valid) begin
                    inst_data_d = imem_rsp_data;
                    inst_pc_d   = pc_q;
                    pc_d        = pc_q + STEP;
                    state_d     = S_HOLD;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    state_d = enable ? S_REQ : S_IDLE;
                end
            end

            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = (redirect_valid || enable) ? S_REQ : S_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == S_HOLD);
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_error    = err_q;

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q;
    logic [31:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else if (state_q == S_HOLD) begin
            if (inst_ready) begin
                fetched_q <= fetched_q + 32'd1;
            end else begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_stall   = stall_q;
`endif

endmodule
